// File: rtl/res_bcd_display.sv
// res_bcd_display: captures a 20-bit ALU result on a load strobe, converts it
// to decimal with a serial shift-add-3 engine and drives six active-low
// seven-segment digits with leading-zero blanking, a minus sign and an
// overflow pattern. Fixed latency of 22 cycles from load to idle.
module res_bcd_display (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] value_in,
  input  logic        signed_mode,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Active-low segment pattern for one decimal digit (bit0=a .. bit6=g).
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  state_t           state;
  logic             neg;
  logic [19:0]      mag;
  logic [27:0]      bcd;
  logic [4:0]       cnt;
  logic [5:0][6:0]  hex_q;

  logic [27:0]      bcd_adj;
  logic [27:0]      bcd_next;
  logic [19:0]      mag_next;
  logic [2:0]       msd;
  logic             ovf_next;
  logic [5:0][6:0]  hex_next;

  // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd, mag}.
  // NOTE: combinational blocks use blocking assignments and give every output a
  // default first, so no latch is inferred on any path.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 7; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_next = {bcd_adj[26:0], mag[19]};
    mag_next = {mag[18:0], 1'b0};
  end

  // Display image of the finished conversion: overflow, blanking, minus sign.
  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < 6; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = 3'(i);
    end
    // Negative values need a free digit for the sign, so they overflow one
    // decade earlier than unsigned ones.
    ovf_next = (bcd[27:24] != 4'd0) || (neg && (bcd[23:20] != 4'd0));
    hex_next = '1;
    for (int i = 0; i < 6; i++) begin
      if (ovf_next)                         hex_next[i] = SEG_MINUS;
      else if (i <= int'(msd))              hex_next[i] = seg7(bcd[4*i +: 4]);
      else if (neg && (i == int'(msd) + 1)) hex_next[i] = SEG_MINUS;
      else                                  hex_next[i] = SEG_BLANK;
    end
  end

  // Control FSM, conversion datapath and registered display outputs.
  // NOTE: sequential state uses non-blocking assignments only; every register,
  // including the scratch and display image, has an explicit reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      neg   <= 1'b0;
      mag   <= '0;
      bcd   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      hex_q <= '1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= load;
          if (load) begin
            neg   <= signed_mode & value_in[19];
            mag   <= (signed_mode & value_in[19]) ? (~value_in + 20'd1) : value_in;
            bcd   <= '0;
            cnt   <= 5'd20;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          bcd <= bcd_next;
          mag <= mag_next;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) state <= UPDATE;
        end
        UPDATE: begin
          hex_q <= hex_next;
          ovf   <= ovf_next;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];

endmodule

// File: tb/tb_res_bcd_display.sv
// Testbench for res_bcd_display: directed vector table, randomized values
// against an arithmetic reference model, overlapping-load and mid-conversion
// reset sequences.
module tb_res_bcd_display;

  localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100,
                         D3 = 7'b0110000, D4 = 7'b0011001, D5 = 7'b0010010,
                         D6 = 7'b0000010, D7 = 7'b1111000, D8 = 7'b0000000,
                         D9 = 7'b0010000, BL = 7'b1111111, MI = 7'b0111111;
  localparam logic [6:0] SEG [10] = '{D0, D1, D2, D3, D4, D5, D6, D7, D8, D9};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] value_in;
  logic        signed_mode;
  logic        load;
  logic        busy, done, ovf;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [41:0] hex_bus;

  int          checks = 0;
  int          errors = 0;
  logic [41:0] prev_hex;

  typedef struct {
    logic [19:0] value;
    logic        mode;
    logic [41:0] hex;   // {hex5, ..., hex0}
    logic        ovf;
  } vec_t;

  vec_t vecs [12];

  res_bcd_display dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value_in    (value_in),
    .signed_mode (signed_mode),
    .load        (load),
    .busy        (busy),
    .done        (done),
    .ovf         (ovf),
    .hex0        (hex0),
    .hex1        (hex1),
    .hex2        (hex2),
    .hex3        (hex3),
    .hex4        (hex4),
    .hex5        (hex5)
  );

  assign hex_bus = {hex5, hex4, hex3, hex2, hex1, hex0};

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: decimal formatting with plain integer arithmetic.
  function automatic void model(input logic [19:0] v, input logic m,
                                output logic [41:0] h, output logic o);
    int  mag, nd, t;
    bit  neg;
    neg = m && v[19];
    mag = neg ? ((1 << 20) - int'(v)) : int'(v);
    o   = neg ? (mag > 99999) : (mag > 999999);
    h   = '1;
    if (o) begin
      h = {6{MI}};
      return;
    end
    nd = 1;
    t  = mag / 10;
    while (t > 0) begin
      nd++;
      t = t / 10;
    end
    t = mag;
    for (int i = 0; i < 6; i++) begin
      if (i < nd) begin
        h[7*i +: 7] = SEG[t % 10];
        t = t / 10;
      end else if (neg && i == nd) begin
        h[7*i +: 7] = MI;
      end else begin
        h[7*i +: 7] = BL;
      end
    end
  endfunction

  // One full conversion with latency, busy/done and result checks.
  // inject_load issues a second load (value 7) at edge k+5, which must be ignored.
  task automatic run(input logic [19:0] v, input logic m,
                     input logic [41:0] eh, input logic eo, input bit inject_load);
    int n;
    bit busy_ok;
    @(negedge clk);
    value_in = v; signed_mode = m; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("busy_after_load", 64'(busy), 64'(1'b1));
    value_in = 20'($urandom);
    signed_mode = ~m;
    n = 0;
    busy_ok = 1'b1;
    while (n < 40) begin
      if (inject_load && n == 4) begin
        load = 1'b1;
        value_in = 20'd7;
        signed_mode = 1'b0;
      end
      @(negedge clk);
      n++;
      load = 1'b0;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (n == 10) check("display_hold", 64'(hex_bus), 64'(prev_hex));
    end
    check("done_latency", 64'(n), 64'(21));
    check("busy_during_conv", 64'(busy_ok), 64'(1'b1));
    check("busy_at_done", 64'(busy), 64'(1'b1));
    check("hex_result", 64'(hex_bus), 64'(eh));
    check("ovf_result", 64'(ovf), 64'(eo));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'(1'b0));
    check("idle_after", 64'(busy), 64'(1'b0));
    prev_hex = eh;
  endtask

  initial begin
    logic [41:0] mh;
    logic        mo;
    logic [19:0] rv;
    logic        rm;
    bit          quiet;

    vecs[0]  = '{20'd491520,  1'b0, {D4, D9, D1, D5, D2, D0}, 1'b0};
    vecs[1]  = '{20'd0,       1'b0, {BL, BL, BL, BL, BL, D0}, 1'b0};
    vecs[2]  = '{20'hFFFF3,   1'b1, {BL, BL, BL, MI, D1, D3}, 1'b0};
    vecs[3]  = '{20'hFFFF3,   1'b0, {6{MI}},                  1'b1};
    vecs[4]  = '{20'h80000,   1'b1, {6{MI}},                  1'b1};
    vecs[5]  = '{20'd999999,  1'b0, {6{D9}},                  1'b0};
    vecs[6]  = '{20'd1000000, 1'b0, {6{MI}},                  1'b1};
    vecs[7]  = '{20'd948577,  1'b1, {MI, D9, D9, D9, D9, D9}, 1'b0};
    vecs[8]  = '{20'd948576,  1'b1, {6{MI}},                  1'b1};
    vecs[9]  = '{20'd7,       1'b1, {BL, BL, BL, BL, BL, D7}, 1'b0};
    vecs[10] = '{20'h80000,   1'b0, {D5, D2, D4, D2, D8, D8}, 1'b0};
    vecs[11] = '{20'hFFFFF,   1'b1, {BL, BL, BL, BL, MI, D1}, 1'b0};

    // Reset state and quiet idle.
    rst_n = 1'b0; load = 1'b0; value_in = '0; signed_mode = 1'b0;
    prev_hex = {6{BL}};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_hex", 64'(hex_bus), 64'({6{BL}}));
    check("reset_busy", 64'(busy), 64'(1'b0));
    check("reset_done", 64'(done), 64'(1'b0));
    check("reset_ovf", 64'(ovf), 64'(1'b0));
    quiet = 1'b1;
    repeat (50) begin
      @(negedge clk);
      value_in = 20'($urandom);
      if (busy || done || ovf || hex_bus !== {6{BL}}) quiet = 1'b0;
    end
    check("idle_no_change", 64'(quiet), 64'(1'b1));

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      run(vecs[i].value, vecs[i].mode, vecs[i].hex, vecs[i].ovf, 1'b0);
    end

    // Randomized values against the reference model.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       rv = 20'($urandom_range(0, 999));
        1:       rv = 20'((1 << 20) - $urandom_range(1, 120000));
        2:       rv = 20'($urandom_range(990000, 1010000));
        default: rv = 20'($urandom);
      endcase
      rm = 1'($urandom);
      model(rv, rm, mh, mo);
      run(rv, rm, mh, mo, 1'b0);
    end

    // Overlapping load at k+5 is ignored: first value shown, one done pulse.
    model(20'd491520, 1'b0, mh, mo);
    run(20'd491520, 1'b0, mh, mo, 1'b1);
    quiet = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) quiet = 1'b0;
    end
    check("no_queued_load", 64'(quiet), 64'(1'b1));
    check("overlap_hex_kept", 64'(hex_bus), 64'({D4, D9, D1, D5, D2, D0}));

    // Put the overflow pattern up, then reset mid-conversion at edge k+10.
    run(20'hFFFF3, 1'b0, {6{MI}}, 1'b1, 1'b0);
    @(negedge clk);
    value_in = 20'd123456; signed_mode = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_hex", 64'(hex_bus), 64'({6{BL}}));
    check("midreset_busy", 64'(busy), 64'(1'b0));
    check("midreset_ovf", 64'(ovf), 64'(1'b0));
    check("midreset_done", 64'(done), 64'(1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done || busy || hex_bus !== {6{BL}}) quiet = 1'b0;
    end
    check("midreset_no_done", 64'(quiet), 64'(1'b1));
    prev_hex = {6{BL}};

    // Recovery after reset.
    model(20'd42, 1'b0, mh, mo);
    run(20'd42, 1'b0, mh, mo, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
